// File: rtl/sfp_cage_manager.sv
// Multi-cage SFP/SFP+ manager: per-cage input conditioning, TX_DISABLE power-up/fault
// sequencing with bounded retries and lockout, and PHY reset/ready indications.
module sfp_cage_manager #(
    parameter int p_CHANNELS    = 1,
    parameter int p_DEBOUNCE    = 1024,
    parameter int p_INSERT_WAIT = 300000,
    parameter int p_FAULT_INIT  = 100000,
    parameter int p_FAULT_HOLD  = 1000,
    parameter int p_MAX_RETRY   = 3
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic [p_CHANNELS-1:0]   i_sfp_los,
    input  logic [p_CHANNELS-1:0]   i_sfp_tx_fault,
    input  logic [p_CHANNELS-1:0]   i_sfp_mod0_prsnt_n,
    input  logic [2*p_CHANNELS-1:0] i_rate_sel,
    input  logic [p_CHANNELS-1:0]   i_retry_clear,
    output logic [p_CHANNELS-1:0]   o_sfp_tx_disable,
    output logic [2*p_CHANNELS-1:0] o_sfp_rate_sel,
    output logic [p_CHANNELS-1:0]   o_phy_reset,
    output logic [p_CHANNELS-1:0]   o_phy_ready,
    output logic [3*p_CHANNELS-1:0] o_state,
    output logic [8*p_CHANNELS-1:0] o_retry_count
);
    localparam int MAX_WAIT_A = (p_INSERT_WAIT > p_FAULT_INIT) ? p_INSERT_WAIT : p_FAULT_INIT;
    localparam int MAX_WAIT   = (MAX_WAIT_A > p_FAULT_HOLD) ? MAX_WAIT_A : p_FAULT_HOLD;
    localparam int TMR_W      = $clog2(MAX_WAIT + 1);
    localparam int DB_W       = $clog2(p_DEBOUNCE + 1);

    localparam logic [TMR_W-1:0] INSERT_LAST = TMR_W'(p_INSERT_WAIT - 1);
    localparam logic [TMR_W-1:0] INIT_LAST   = TMR_W'(p_FAULT_INIT - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST   = TMR_W'(p_FAULT_HOLD - 1);
    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(p_DEBOUNCE - 1);
    localparam logic [7:0]       RETRY_LIMIT = 8'(p_MAX_RETRY);
    // Filter bit order is {mod_abs, tx_fault, los}; idle state is absent, no fault, no signal.
    localparam logic [2:0]       FILT_RST    = 3'b101;

    typedef enum logic [2:0] {
        ST_ABSENT      = 3'd0,
        ST_INSERT_WAIT = 3'd1,
        ST_TX_ON       = 3'd2,
        ST_LINK_WAIT   = 3'd3,
        ST_READY       = 3'd4,
        ST_FAULT_HOLD  = 3'd5,
        ST_LOCKOUT     = 3'd6
    } state_t;

    logic [2*p_CHANNELS-1:0] rate_sel_q, rate_sel_d;

    always_comb begin
        rate_sel_d = i_rate_sel;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            rate_sel_q <= '0;
        end else begin
            rate_sel_q <= rate_sel_d;
        end
    end

    assign o_sfp_rate_sel = rate_sel_q;

    for (genvar gi = 0; gi < p_CHANNELS; gi++) begin : g_chan
        logic [2:0] raw;
        logic [2:0] filt;
        logic       mod_abs, fault, los;

        assign raw     = {i_sfp_mod0_prsnt_n[gi], i_sfp_tx_fault[gi], i_sfp_los[gi]};
        assign mod_abs = filt[2];
        assign fault   = filt[1];
        assign los     = filt[0];

        for (genvar bi = 0; bi < 3; bi++) begin : g_filt
            logic            sync1_q, sync2_q;
            logic            filt_q, filt_d;
            logic [DB_W-1:0] cnt_q, cnt_d;

            // Counter runs only while the synchronised level disagrees with the filtered one.
            always_comb begin
                filt_d = filt_q;
                cnt_d  = '0;
                if (sync2_q != filt_q) begin
                    if (cnt_q == DB_LAST) begin
                        filt_d = sync2_q;
                    end else begin
                        cnt_d = cnt_q + DB_W'(1);
                    end
                end
            end

            always_ff @(posedge i_clock) begin
                if (i_reset) begin
                    sync1_q <= FILT_RST[bi];
                    sync2_q <= FILT_RST[bi];
                    filt_q  <= FILT_RST[bi];
                    cnt_q   <= '0;
                end else begin
                    sync1_q <= raw[bi];
                    sync2_q <= sync1_q;
                    filt_q  <= filt_d;
                    cnt_q   <= cnt_d;
                end
            end

            assign filt[bi] = filt_q;
        end

        state_t           state_q, state_d;
        logic [TMR_W-1:0] timer_q, timer_d;
        logic [7:0]       retry_q, retry_d;
        logic             tx_dis_q, tx_dis_d;
        logic             phy_reset_q, phy_reset_d;
        logic             phy_ready_q, phy_ready_d;

        always_comb begin
            state_d = state_q;
            retry_d = retry_q;
            timer_d = '0;
            case (state_q)
                ST_ABSENT: begin
                    if (!mod_abs) state_d = ST_INSERT_WAIT;
                end
                ST_INSERT_WAIT: begin
                    if (timer_q == INSERT_LAST) state_d = ST_TX_ON;
                end
                ST_TX_ON: begin
                    if (fault) begin
                        state_d = ST_FAULT_HOLD;
                    end else if (timer_q == INIT_LAST) begin
                        state_d = ST_LINK_WAIT;
                    end
                end
                ST_LINK_WAIT: begin
                    if (fault) begin
                        state_d = ST_FAULT_HOLD;
                    end else if (!los) begin
                        state_d = ST_READY;
                        retry_d = '0;
                    end
                end
                ST_READY: begin
                    if (fault) begin
                        state_d = ST_FAULT_HOLD;
                    end else if (los) begin
                        state_d = ST_LINK_WAIT;
                    end
                end
                ST_FAULT_HOLD: begin
                    if (timer_q == HOLD_LAST) begin
                        if (retry_q == RETRY_LIMIT) begin
                            state_d = ST_LOCKOUT;
                        end else begin
                            state_d = ST_TX_ON;
                            retry_d = retry_q + 8'd1;
                        end
                    end
                end
                ST_LOCKOUT: begin
                    if (i_retry_clear[gi]) begin
                        state_d = ST_INSERT_WAIT;
                        retry_d = '0;
                    end
                end
                default: state_d = ST_ABSENT;
            endcase

            // Module removal overrides every other transition.
            if (mod_abs) begin
                state_d = ST_ABSENT;
                retry_d = '0;
            end

            if (state_d != state_q) begin
                timer_d = '0;
            end else if (state_q == ST_INSERT_WAIT || state_q == ST_TX_ON ||
                         state_q == ST_FAULT_HOLD) begin
                timer_d = timer_q + TMR_W'(1);
            end
        end

        always_comb begin
            tx_dis_d    = (state_q == ST_ABSENT) || (state_q == ST_INSERT_WAIT) ||
                          (state_q == ST_FAULT_HOLD) || (state_q == ST_LOCKOUT);
            phy_reset_d = !((state_q == ST_LINK_WAIT) || (state_q == ST_READY));
            phy_ready_d = (state_q == ST_READY);
        end

        always_ff @(posedge i_clock) begin
            if (i_reset) begin
                state_q     <= ST_ABSENT;
                timer_q     <= '0;
                retry_q     <= '0;
                tx_dis_q    <= 1'b1;
                phy_reset_q <= 1'b1;
                phy_ready_q <= 1'b0;
            end else begin
                state_q     <= state_d;
                timer_q     <= timer_d;
                retry_q     <= retry_d;
                tx_dis_q    <= tx_dis_d;
                phy_reset_q <= phy_reset_d;
                phy_ready_q <= phy_ready_d;
            end
        end

        assign o_sfp_tx_disable[gi]  = tx_dis_q;
        assign o_phy_reset[gi]       = phy_reset_q;
        assign o_phy_ready[gi]       = phy_ready_q;
        assign o_state[3*gi +: 3]    = state_q;
        assign o_retry_count[8*gi +: 8] = retry_q;
    end

endmodule

// File: tb/tb_sfp_cage_manager.sv
// Directed bench for sfp_cage_manager: insertion, glitch rejection, fault retry,
// lockout, removal and mid-run reset, with cycle-exact expected values.
module tb_sfp_cage_manager;
    localparam int CH = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] los, fault, prsnt_n, clr;
    logic [2*CH-1:0] rate;
    logic [CH-1:0] tx_dis, phy_rst, phy_rdy;
    logic [2*CH-1:0] rate_out;
    logic [3*CH-1:0] state;
    logic [8*CH-1:0] retry;

    int checks = 0;
    int errors = 0;

    sfp_cage_manager #(
        .p_CHANNELS(CH), .p_DEBOUNCE(4), .p_INSERT_WAIT(16),
        .p_FAULT_INIT(8), .p_FAULT_HOLD(10), .p_MAX_RETRY(2)
    ) dut (
        .i_clock(clk),
        .i_reset(rst),
        .i_sfp_los(los),
        .i_sfp_tx_fault(fault),
        .i_sfp_mod0_prsnt_n(prsnt_n),
        .i_rate_sel(rate),
        .i_retry_clear(clr),
        .o_sfp_tx_disable(tx_dis),
        .o_sfp_rate_sel(rate_out),
        .o_phy_reset(phy_rst),
        .o_phy_ready(phy_rdy),
        .o_state(state),
        .o_retry_count(retry)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("[%0t] %s observed=%0h expected=%0h", $time, tag, obs, exp);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_txdis"}, 32'(tx_dis), 32'h3);
        chk({tag, "_phyrst"}, 32'(phy_rst), 32'h3);
        chk({tag, "_phyrdy"}, 32'(phy_rdy), 32'h0);
        chk({tag, "_state"}, 32'(state), 32'h0);
        chk({tag, "_retry"}, 32'(retry), 32'h0);
        chk({tag, "_rate"}, 32'(rate_out), 32'h0);
    endtask

    initial begin
        rst = 1'b1; los = 2'b11; fault = 2'b00; prsnt_n = 2'b11; clr = 2'b00; rate = 4'b0111;
        tick(3);
        chk_reset_vals("por");
        rst = 1'b0;
        tick(1);
        chk("por_rate_copy", 32'(rate_out), 32'h7);
        chk("por_state", 32'(state), 32'h0);

        // Insertion: TX enables 24 cycles after the presence edge.
        prsnt_n = 2'b10;
        tick(23);
        chk("ins_txon_state", 32'(state[2:0]), 32'd2);
        chk("ins_txdis_before", 32'(tx_dis[0]), 32'd1);
        tick(1);
        chk("ins_txdis_edge", 32'(tx_dis[0]), 32'd0);
        chk("ins_ch1_txdis", 32'(tx_dis[1]), 32'd1);
        los = 2'b10;
        tick(7);
        chk("ins_linkwait", 32'(state[2:0]), 32'd3);
        chk("ins_phyrst_hi", 32'(phy_rst[0]), 32'd1);
        tick(1);
        chk("ins_ready_state", 32'(state[2:0]), 32'd4);
        chk("ins_phyrst_lo", 32'(phy_rst[0]), 32'd0);
        chk("ins_rdy_lag", 32'(phy_rdy[0]), 32'd0);
        tick(1);
        chk("ins_phy_ready", 32'(phy_rdy[0]), 32'd1);
        chk("ins_ch1_absent", 32'(state[5:3]), 32'd0);

        // Three-cycle glitches must not propagate; clear is ignored outside LOCKOUT.
        los = 2'b11; tick(3); los = 2'b10; tick(10);
        chk("glitch_los_state", 32'(state[2:0]), 32'd4);
        chk("glitch_los_rdy", 32'(phy_rdy[0]), 32'd1);
        fault = 2'b01; tick(3); fault = 2'b00; tick(10);
        chk("glitch_flt_state", 32'(state[2:0]), 32'd4);
        chk("glitch_flt_txdis", 32'(tx_dis[0]), 32'd0);
        prsnt_n = 2'b11; tick(3); prsnt_n = 2'b10; tick(10);
        chk("glitch_abs_state", 32'(state[2:0]), 32'd4);
        chk("glitch_abs_rdy", 32'(phy_rdy[0]), 32'd1);
        clr = 2'b01; tick(1); clr = 2'b00; tick(2);
        chk("clr_ignored", 32'(state[2:0]), 32'd4);

        // Six-cycle fault in READY: one recovery, then READY clears the count.
        fault = 2'b01;
        tick(6);
        chk("flt_still_ready", 32'(state[2:0]), 32'd4);
        fault = 2'b00;
        tick(1);
        chk("flt_hold_state", 32'(state[2:0]), 32'd5);
        chk("flt_txdis_lag", 32'(tx_dis[0]), 32'd0);
        tick(1);
        chk("flt_txdis_on", 32'(tx_dis[0]), 32'd1);
        chk("flt_phyrst_on", 32'(phy_rst[0]), 32'd1);
        tick(9);
        chk("flt_txon_state", 32'(state[2:0]), 32'd2);
        chk("flt_retry1", 32'(retry[7:0]), 32'd1);
        chk("flt_txdis_last", 32'(tx_dis[0]), 32'd1);
        tick(1);
        chk("flt_txdis_off", 32'(tx_dis[0]), 32'd0);
        tick(7);
        chk("flt_linkwait", 32'(state[2:0]), 32'd3);
        chk("flt_retry_kept", 32'(retry[7:0]), 32'd1);
        tick(1);
        chk("flt_ready_again", 32'(state[2:0]), 32'd4);
        chk("flt_retry_clr", 32'(retry[7:0]), 32'd0);

        // Persistent fault: two recoveries, then lockout.
        fault = 2'b01;
        tick(17);
        chk("lk_txon1", 32'(state[2:0]), 32'd2);
        chk("lk_retry1", 32'(retry[7:0]), 32'd1);
        tick(1);
        chk("lk_hold2", 32'(state[2:0]), 32'd5);
        tick(10);
        chk("lk_txon2", 32'(state[2:0]), 32'd2);
        chk("lk_retry2", 32'(retry[7:0]), 32'd2);
        tick(10);
        chk("lk_hold3", 32'(state[2:0]), 32'd5);
        tick(1);
        chk("lk_lockout", 32'(state[2:0]), 32'd6);
        chk("lk_retry_held", 32'(retry[7:0]), 32'd2);
        tick(1);
        chk("lk_txdis", 32'(tx_dis[0]), 32'd1);
        fault = 2'b00;
        tick(10);
        chk("lk_stays", 32'(state[2:0]), 32'd6);
        clr = 2'b11; tick(1); clr = 2'b00;
        chk("lk_clear_state", 32'(state[2:0]), 32'd1);
        chk("lk_clear_retry", 32'(retry[7:0]), 32'd0);
        chk("lk_clear_ch1", 32'(state[5:3]), 32'd0);

        // Removal during the second FAULT_HOLD.
        tick(16);
        chk("rm_txon", 32'(state[2:0]), 32'd2);
        fault = 2'b01;
        tick(19);
        chk("rm_hold", 32'(state[2:0]), 32'd5);
        chk("rm_retry1", 32'(retry[7:0]), 32'd1);
        prsnt_n = 2'b11; fault = 2'b00;
        tick(6);
        chk("rm_hold_kept", 32'(state[2:0]), 32'd5);
        tick(1);
        chk("rm_absent", 32'(state[2:0]), 32'd0);
        chk("rm_retry0", 32'(retry[7:0]), 32'd0);
        tick(1);
        chk("rm_txdis", 32'(tx_dis[0]), 32'd1);
        chk("rm_phyrst", 32'(phy_rst[0]), 32'd1);

        // Reinsert to READY, exercise rate select, then reset mid-run.
        prsnt_n = 2'b10;
        tick(33);
        chk("re_ready", 32'(state[2:0]), 32'd4);
        chk("re_phy_ready", 32'(phy_rdy[0]), 32'd1);
        rate = 4'b1001; tick(1);
        chk("rate_change", 32'(rate_out), 32'h9);
        rate = 4'b0111; tick(1);
        chk("rate_restore", 32'(rate_out), 32'h7);
        rst = 1'b1; tick(1);
        chk_reset_vals("mid_rst");
        rst = 1'b0; tick(1);
        chk("post_rst_rate", 32'(rate_out), 32'h7);
        chk("post_rst_state", 32'(state[2:0]), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
